solution_disassembler: RTL and testbench
========================================

Name: solution_disassembler

Overview:
- Receive-side counterpart of the solution assembler.
- Consumes the byte stream the assembler emits (after UART RX), rebuilds 16-bit protocol words, and decodes the frame back into grid dimensions plus an 11x11 solution bitmap.
- Used for loopback checking of the transmit path and for loading a known solution from the host.

Parameters:
- MAX_DIM, 11, maximum rows/columns; solution width is MAX_DIM*MAX_DIM.
- TIMEOUT_CYCLES, 100000, clock cycles allowed between high and low byte of one word before the half-word is discarded.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- valid_in  in  1  one-cycle strobe: byte_in is valid
- byte_in  in  8  received byte
- solution  out  121  decoded grid; row r, col c at bit r*11+c
- m  out  4  decoded row count
- n  out  4  decoded column count
- valid_out  out  1  one-cycle pulse: frame complete, outputs consistent
- error  out  1  one-cycle pulse: protocol violation, frame dropped
- busy  out  1  high while a frame is in progress (after accepted M word, until STOP/error)

Behaviour:
- Reset (rst==0 at posedge): solution=0, m=0, n=0, valid_out=0, error=0, busy=0, byte phase=HIGH, FSM=WAIT_M, row counter=0, timeout counter=0.
- Word assembly: words are big-endian, high byte first.
  - Phase HIGH + valid_in: latch byte, go to LOW.
  - Phase LOW + valid_in: word = {latched, byte_in}, decode the word in the same cycle, return to HIGH.
  - valid_in low: no state change, except the timeout counter.
- Timeout: in phase LOW the counter increments each cycle without valid_in. When it reaches TIMEOUT_CYCLES-1, the next cycle returns to HIGH and discards the latched byte. No error pulse; FSM state is kept. The counter clears on every accepted byte.
- Word encoding, opcode = word[15:13]:
  - 3'b111: SIZE, value = word[3:0].
  - 3'b100: ROW, bits = word[10:0].
  - 16'h0000: STOP.
  - Anything else is illegal.
- FSM, transitions only on a completed word:
  - WAIT_M:
    - SIZE with 1<=value<=11: m<=value, solution<=0, row counter<=0, busy<=1, go to WAIT_N.
    - STOP: ignored (idle filler).
    - Any other word: error.
  - WAIT_N:
    - SIZE with 1<=value<=11: n<=value, go to ROWS.
    - Any other word: error.
  - ROWS:
    - ROW while row counter < m: solution[row*11 +: 11] <= bits with columns >= n forced to 0; row counter++.
    - ROW while row counter == m: error.
    - STOP while row counter == m: valid_out pulses the next cycle, busy<=0, go to WAIT_M.
    - STOP while row counter < m: error.
    - SIZE: error.
- Error action: error pulses 1 cycle (next cycle after the offending word); busy<=0; FSM goes to WAIT_M; row counter clears. solution, m and n keep partial contents but are not qualified by valid_out.
- solution, m and n hold their values between frames until the next accepted M word.
- Latency: valid_out is high exactly one cycle, in the cycle after the posedge that accepts STOP's low byte.
- Reset mid-frame discards everything and returns to the reset values above.
- valid_out and error are never high in the same cycle.
- Width rules: row counter 4 bits; bit offset computed as row*11 in 7 bits, max 110.

Test Plan:
- Frame E000_E003? no; the exact frame is: bytes E0 03, E0 03, 80 03, 80 02, 85 FF, 00 00 -> valid_out one pulse; m=3, n=3; solution = {88'b0, 11'b000_0000_0111 (row2 masked to n=3), 11'h002, 11'h003}; busy low after.
- SIZE m=0 (E0 00) in WAIT_M -> error pulse, busy stays 0, FSM in WAIT_M; following valid 1x1 frame E0 01, E0 01, 80 01, 00 00 -> valid_out, solution[0]=1.
- m=2, n=2, one ROW then STOP -> error pulse, no valid_out; m=2 then 3 ROWs -> error on the third ROW.
- Leading 00 00 filler words before E0 02 -> no error, frame decodes normally.
- High byte E0 then idle TIMEOUT_CYCLES cycles (bench sets 16), then E0 04 E0 04 … -> stream resynchronised, frame decodes with m=4, n=4.
- rst=0 for one cycle after two ROW words of a 3x3 frame -> all outputs 0; a new full frame then decodes correctly; valid_in gaps of 0-5 cycles between bytes give identical results.

Source files
------------

// File: rtl/solution_disassembler.sv
// rtl/solution_disassembler.sv - byte stream to solution frame decoder
//
// Rebuilds big-endian 16-bit protocol words from received bytes and decodes
// SIZE(M), SIZE(N), M x ROW, STOP frames into grid dimensions and a bitmap.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-low
//   valid_in   one-cycle strobe, byte_in valid
//   byte_in    received byte
//   solution   decoded grid, row r col c at bit r*MAX_DIM+c
//   m, n       decoded row / column counts
//   valid_out  one-cycle pulse, frame complete
//   error      one-cycle pulse, protocol violation, frame dropped
//   busy       frame in progress (accepted M word until STOP/error)
module solution_disassembler #(
  parameter int MAX_DIM        = 11,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [7:0]                   byte_in,
  output logic [MAX_DIM*MAX_DIM-1:0]   solution,
  output logic [3:0]                   m,
  output logic [3:0]                   n,
  output logic                         valid_out,
  output logic                         error,
  output logic                         busy
);

  localparam int SOL_W  = MAX_DIM * MAX_DIM;
  localparam int OFF_W  = $clog2(SOL_W);
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_WAIT_M, S_WAIT_N, S_ROWS} state_t;

  state_t              state_q, state_d;
  logic                phase_low_q, phase_low_d;
  logic [7:0]          hi_byte_q, hi_byte_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [3:0]          row_q, row_d;
  logic [SOL_W-1:0]    sol_q, sol_d;
  logic [3:0]          m_q, m_d;
  logic [3:0]          n_q, n_d;
  logic                valid_q, valid_d;
  logic                error_q, error_d;
  logic                busy_q, busy_d;

  logic                word_done;
  logic [15:0]         word;
  logic                is_size, size_ok, is_row, is_stop, rows_full, proto_err;
  logic [MAX_DIM-1:0]  row_bits;
  logic [OFF_W-1:0]    row_off;

  always_comb begin
    state_d     = state_q;
    phase_low_d = phase_low_q;
    hi_byte_d   = hi_byte_q;
    tcnt_d      = tcnt_q;
    row_d       = row_q;
    sol_d       = sol_q;
    m_d         = m_q;
    n_d         = n_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    error_d     = 1'b0;
    word_done   = 1'b0;
    proto_err   = 1'b0;
    word        = {hi_byte_q, byte_in};

    // Byte pairing; a stalled low byte is silently dropped so the stream
    // can resynchronise on the next high byte.
    if (phase_low_q) begin
      if (valid_in) begin
        phase_low_d = 1'b0;
        tcnt_d      = '0;
        word_done   = 1'b1;
      end else if (tcnt_q == TCNT_MAX) begin
        phase_low_d = 1'b0;
        tcnt_d      = '0;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end else if (valid_in) begin
      hi_byte_d   = byte_in;
      phase_low_d = 1'b1;
      tcnt_d      = '0;
    end

    is_size   = (word[15:13] == 3'b111);
    size_ok   = (word[3:0] != 4'd0) && (word[3:0] <= 4'(MAX_DIM));
    is_row    = (word[15:13] == 3'b100);
    is_stop   = (word == 16'h0000);
    rows_full = (row_q == m_q);
    row_off   = OFF_W'(row_q) * OFF_W'(MAX_DIM);

    // Columns at or beyond n are forced to zero.
    for (int c = 0; c < MAX_DIM; c++) begin
      row_bits[c] = word[c] & (c < int'(n_q));
    end

    if (word_done) begin
      case (state_q)
        S_WAIT_M: begin
          if (is_size && size_ok) begin
            m_d     = word[3:0];
            sol_d   = '0;
            row_d   = '0;
            busy_d  = 1'b1;
            state_d = S_WAIT_N;
          end else if (!is_stop) begin
            proto_err = 1'b1;
          end
        end
        S_WAIT_N: begin
          if (is_size && size_ok) begin
            n_d     = word[3:0];
            state_d = S_ROWS;
          end else begin
            proto_err = 1'b1;
          end
        end
        S_ROWS: begin
          if (is_row && !rows_full) begin
            sol_d[row_off +: MAX_DIM] = row_bits;
            row_d = row_q + 4'd1;
          end else if (is_stop && rows_full) begin
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_WAIT_M;
          end else begin
            proto_err = 1'b1;
          end
        end
        default: state_d = S_WAIT_M;
      endcase
    end

    if (proto_err) begin
      error_d = 1'b1;
      busy_d  = 1'b0;
      row_d   = '0;
      state_d = S_WAIT_M;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_WAIT_M;
      phase_low_q <= 1'b0;
      hi_byte_q   <= '0;
      tcnt_q      <= '0;
      row_q       <= '0;
      sol_q       <= '0;
      m_q         <= '0;
      n_q         <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_low_q <= phase_low_d;
      hi_byte_q   <= hi_byte_d;
      tcnt_q      <= tcnt_d;
      row_q       <= row_d;
      sol_q       <= sol_d;
      m_q         <= m_d;
      n_q         <= n_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
    end
  end

  assign solution  = sol_q;
  assign m         = m_q;
  assign n         = n_q;
  assign valid_out = valid_q;
  assign error     = error_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_solution_disassembler.sv
// tb/tb_solution_disassembler.sv - self-checking bench for solution_disassembler
module tb_solution_disassembler;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid_in = 1'b0;
  logic [7:0]   byte_in = 8'h00;
  logic [120:0] solution;
  logic [3:0]   m, n;
  logic         valid_out, error, busy;

  always #5 clk = ~clk;

  solution_disassembler #(.MAX_DIM(11), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .byte_in(byte_in),
    .solution(solution), .m(m), .n(n),
    .valid_out(valid_out), .error(error), .busy(busy)
  );

  typedef struct {
    logic         err;
    logic [3:0]   m;
    logic [3:0]   n;
    logic [120:0] sol;
  } ev_t;

  typedef struct {
    logic [255:0] v;
    int           nb;
    logic         err;
    logic [3:0]   m;
    logic [3:0]   n;
    logic [120:0] sol;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  obs_q[$];
  ev_t  exp_q[$];
  vec_t tbl[$];

  // reference model state (frame-level)
  int           md_st;
  int           md_row;
  logic [3:0]   md_m, md_n;
  logic [120:0] md_sol;
  logic         md_busy;

  always @(negedge clk) begin
    if (valid_out || error) begin
      n_cmp++;
      if (valid_out && error) begin
        n_bad++;
        $display("FAIL excl: valid_out=%b error=%b both high", valid_out, error);
      end
      obs_q.push_back('{error, m, n, solution});
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    idle(gap);
    valid_in = 1'b1;
    byte_in  = b;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    byte_in  = $urandom();
  endtask

  task automatic send_vec(input logic [255:0] v, input int nb, input int maxgap);
    for (int i = 0; i < nb; i++) begin
      send_byte(v[8*(nb-1-i) +: 8], $urandom_range(0, maxgap));
    end
  endtask

  task automatic check_events(input string nm, input logic busy_exp);
    int k;
    idle(3);
    chk({nm, ".events"}, obs_q.size(), exp_q.size());
    k = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < k; i++) begin
      chk($sformatf("%s.e%0d.err", nm, i), obs_q[i].err, exp_q[i].err);
      chk($sformatf("%s.e%0d.m", nm, i), obs_q[i].m, exp_q[i].m);
      chk($sformatf("%s.e%0d.n", nm, i), obs_q[i].n, exp_q[i].n);
      chk($sformatf("%s.e%0d.sol", nm, i), obs_q[i].sol, exp_q[i].sol);
    end
    chk({nm, ".busy"}, busy, busy_exp);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    md_st = 0; md_row = 0; md_m = '0; md_n = '0; md_sol = '0; md_busy = 1'b0;
  endtask

  task automatic model_word(input logic [15:0] w);
    logic sz, ok, rw, stp, bad;
    int   v;
    sz  = (w[15:13] == 3'b111);
    v   = int'(w[3:0]);
    ok  = (v >= 1) && (v <= 11);
    rw  = (w[15:13] == 3'b100);
    stp = (w == 16'h0000);
    bad = 1'b0;
    if (md_st == 0) begin
      if (sz && ok) begin
        md_m = 4'(v); md_sol = '0; md_row = 0; md_busy = 1'b1; md_st = 1;
      end else if (!stp) bad = 1'b1;
    end else if (md_st == 1) begin
      if (sz && ok) begin
        md_n = 4'(v); md_st = 2;
      end else bad = 1'b1;
    end else begin
      if (rw && md_row < int'(md_m)) begin
        for (int c = 0; c < 11; c++) md_sol[md_row*11 + c] = w[c] && (c < int'(md_n));
        md_row++;
      end else if (stp && md_row == int'(md_m)) begin
        exp_q.push_back('{1'b0, md_m, md_n, md_sol});
        md_busy = 1'b0; md_st = 0;
      end else bad = 1'b1;
    end
    if (bad) begin
      exp_q.push_back('{1'b1, md_m, md_n, md_sol});
      md_busy = 1'b0; md_st = 0; md_row = 0;
    end
  endtask

  function automatic int pick_dim();
    if ($urandom_range(0, 9) == 0) return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(12, 15));
    return int'($urandom_range(1, 11));
  endfunction

  initial begin
    logic [120:0] s1, ones;
    logic [15:0]  ws[$];
    int           mv, nv, nr, k;

    s1   = (121'(7) << 22) | (121'(2) << 11) | 121'(3);
    ones = '1;
    tbl.push_back('{256'(96'hE003_E003_8003_8002_85FF_0000), 12, 1'b0, 4'd3, 4'd3, s1});
    tbl.push_back('{256'(16'hE000), 2, 1'b1, 4'd3, 4'd3, s1});
    tbl.push_back('{256'(64'hE001_E001_8001_0000), 8, 1'b0, 4'd1, 4'd1, 121'(1)});
    tbl.push_back('{256'(64'hE002_E002_8001_0000), 8, 1'b1, 4'd2, 4'd2, 121'(1)});
    tbl.push_back('{256'(80'hE002_E002_8001_8003_8007), 10, 1'b1, 4'd2, 4'd2, 121'(1) | (121'(3) << 11)});
    tbl.push_back('{256'(112'h0000_0000_E002_E002_8003_8001_0000), 14, 1'b0, 4'd2, 4'd2, 121'(3) | (121'(1) << 11)});
    tbl.push_back('{256'({16'hE00B, 16'hE00B, {11{16'h87FF}}, 16'h0000}), 28, 1'b0, 4'd11, 4'd11, ones});
    tbl.push_back('{256'(16'hE00C), 2, 1'b1, 4'd11, 4'd11, ones});
    tbl.push_back('{256'(48'hE001_E001_E001), 6, 1'b1, 4'd1, 4'd1, 121'(0)});
    tbl.push_back('{256'(32'hE002_0000), 4, 1'b1, 4'd2, 4'd1, 121'(0)});
    tbl.push_back('{256'(16'h8005), 2, 1'b1, 4'd2, 4'd1, 121'(0)});
    tbl.push_back('{256'(80'hFFF2_F013_8FFF_8FFF_0000), 10, 1'b0, 4'd2, 4'd3, 121'(7) | (121'(7) << 11)});

    // reset values
    rst = 1'b0;
    idle(2);
    chk("rst.solution", solution, 0);
    chk("rst.m", m, 0);
    chk("rst.n", n, 0);
    chk("rst.valid_out", valid_out, 0);
    chk("rst.error", error, 0);
    chk("rst.busy", busy, 0);
    rst = 1'b1;
    idle(1);

    // table vectors, back-to-back bytes then random gaps 0-5
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < tbl.size(); i++) begin
        exp_q.push_back('{tbl[i].err, tbl[i].m, tbl[i].n, tbl[i].sol});
        send_vec(tbl[i].v, tbl[i].nb, pass * 5);
        check_events($sformatf("p%0d.vec%0d", pass, i), 1'b0);
      end
    end

    // lone high byte then TO idle cycles: half-word must be discarded
    send_byte(8'hE0, 0);
    idle(TO);
    exp_q.push_back('{1'b0, 4'd4, 4'd4, 121'h00F | (121'h00F << 11) | (121'h00F << 22) | (121'h00F << 33)});
    send_vec(256'(128'hE004_E004_800F_800F_800F_800F), 12, 0);
    send_vec(256'(16'h0000), 2, 0);
    check_events("timeout", 1'b0);

    // gap just inside the timeout window keeps the high byte
    send_byte(8'hE0, 0);
    idle(TO - 2);
    send_byte(8'h02, 0);
    exp_q.push_back('{1'b0, 4'd2, 4'd2, 121'(1) | (121'(2) << 11)});
    send_vec(256'(64'hE002_8001_8002_0000), 8, 0);
    check_events("no_timeout", 1'b0);

    // reset mid-frame, with a half word pending
    send_vec(256'(64'hE003_E003_8007_8007), 8, 0);
    send_byte(8'h80, 0);
    chk("mid.busy_before", busy, 1);
    do_reset();
    chk("mid.solution", solution, 0);
    chk("mid.m", m, 0);
    chk("mid.n", n, 0);
    chk("mid.busy", busy, 0);
    chk("mid.valid_out", valid_out, 0);
    chk("mid.error", error, 0);
    exp_q.push_back('{1'b0, 4'd3, 4'd3, 121'(1) | (121'(2) << 11) | (121'(4) << 22)});
    send_vec(256'(96'hE003_E003_8001_8002_8004_0000), 12, 5);
    check_events("mid.after", 1'b0);

    // randomized frames against the model
    do_reset();
    for (int f = 0; f < 60; f++) begin
      ws.delete();
      if ($urandom_range(0, 3) == 0) ws.push_back(16'h0000);
      mv = pick_dim();
      nv = pick_dim();
      ws.push_back({3'b111, 9'($urandom), 4'(mv)});
      ws.push_back({3'b111, 9'($urandom), 4'(nv)});
      k  = $urandom_range(0, 7);
      nr = (k == 0 && mv > 0) ? mv - 1 : ((k == 1) ? mv + 1 : mv);
      for (int r = 0; r < nr; r++) ws.push_back({3'b100, 2'($urandom), 11'($urandom)});
      if ($urandom_range(0, 7) == 0) ws.push_back(16'($urandom));
      else ws.push_back(16'h0000);
      if ($urandom_range(0, 9) == 0) ws[$urandom_range(0, ws.size() - 1)] = 16'($urandom);
      foreach (ws[i]) begin
        model_word(ws[i]);
        send_byte(ws[i][15:8], $urandom_range(0, 5));
        send_byte(ws[i][7:0], $urandom_range(0, 5));
      end
      check_events($sformatf("rnd%0d", f), md_busy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
